// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: credit-limited word requests, in-order response FIFO with PCs, redirect flush.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (sticky misaligned-redirect flag that halts issue).
module ifetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             mem_req_o,
    output logic [WIDTH-1:0] mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             instr_valid_o,
    output logic [31:0]      instr_o,
    output logic [WIDTH-1:0] instr_pc_o,
    input  logic             instr_ready_i,
    output logic             misalign_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   fetch_pc_reg, fetch_pc_next;
    logic [WIDTH-1:0]   resp_pc_reg, resp_pc_next;
    logic [CW-1:0]      outstanding_reg, outstanding_next;
    logic [CW-1:0]      discard_reg, discard_next;
    logic [CW-1:0]      count_reg, count_next;
    logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
    logic               req_reg, req_next;
    logic               valid_reg, valid_next;
    logic [31:0]        instr_reg, instr_next;
    logic [WIDTH-1:0]   instr_pc_reg, instr_pc_next;
    logic               misalign_reg, misalign_next;

    logic [31+WIDTH:0]  fifo_mem [DEPTH];
    logic [31+WIDTH:0]  push_data;
    logic [31+WIDTH:0]  head_data;

    logic               gnt_fire, rvalid_ok, drop, accept, pop, push;
    logic [CW:0]        inflight_after;
    logic [CW:0]        credit_sum;
    logic [WIDTH-1:0]   target;
    logic               target_misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target            = redirect_pc_i;
    assign target_misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
    assign target            = redirect_pc_i & ~WIDTH'(3);
    assign target_misaligned = 1'b0;
`endif

    assign gnt_fire  = req_reg & mem_gnt_i;
    // A response nobody is waiting for is a protocol error and is ignored outright.
    assign rvalid_ok = mem_rvalid_i & ((outstanding_reg != '0) | (discard_reg != '0));
    assign drop      = rvalid_ok & (discard_reg != '0);
    assign accept    = rvalid_ok & (discard_reg == '0);
    assign pop       = valid_reg & instr_ready_i;
    assign push_data = {mem_rdata_i, resp_pc_reg};

    assign inflight_after = {1'b0, outstanding_reg} + {1'b0, discard_reg}
                          + (CW+1)'(gnt_fire) - (CW+1)'(rvalid_ok);

    always_comb begin
        state_next       = state_reg;
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;
        count_next       = count_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;
        valid_next       = valid_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        misalign_next    = misalign_reg;
        push             = 1'b0;
        head_data        = '0;

        if (redirect_i) begin
            // Everything still owed by memory, including this cycle's grant, becomes stale.
            state_next       = (inflight_after != '0) ? FLUSH : RUN;
            fetch_pc_next    = target;
            resp_pc_next     = target;
            discard_next     = CW'(inflight_after);
            outstanding_next = '0;
            count_next       = '0;
            rd_ptr_next      = '0;
            wr_ptr_next      = '0;
            valid_next       = 1'b0;
            misalign_next    = target_misaligned;
        end else begin
            if (gnt_fire)
                fetch_pc_next = fetch_pc_reg + WIDTH'(4);
            outstanding_next = outstanding_reg + CW'(gnt_fire) - CW'(accept);
            if (drop)
                discard_next = discard_reg - CW'(1);

            push = accept;
            if (push) begin
                resp_pc_next = resp_pc_reg + WIDTH'(4);
                wr_ptr_next  = wr_ptr_reg + AW'(1);
            end
            if (pop)
                rd_ptr_next = rd_ptr_reg + AW'(1);
            count_next = count_reg + CW'(push) - CW'(pop);

            // The head register reloads from the slot that will be at the front next cycle.
            if (count_next != '0) begin
                head_data     = (push && (rd_ptr_next == wr_ptr_reg)) ? push_data : fifo_mem[rd_ptr_next];
                valid_next    = 1'b1;
                instr_next    = head_data[31+WIDTH:WIDTH];
                instr_pc_next = head_data[WIDTH-1:0];
            end else begin
                valid_next    = 1'b0;
            end

            case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     state_next = RUN;
                FLUSH:   state_next = (discard_next == '0) ? RUN : FLUSH;
                default: state_next = IDLE;
            endcase
        end

        credit_sum = {1'b0, count_next} + {1'b0, outstanding_next};
        req_next   = (state_next == RUN) && (credit_sum < (CW+1)'(DEPTH)) && !misalign_next;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg       <= IDLE;
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            req_reg         <= 1'b0;
            valid_reg       <= 1'b0;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            misalign_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            count_reg       <= count_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            req_reg         <= req_next;
            valid_reg       <= valid_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            misalign_reg    <= misalign_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !redirect_i)
            fifo_mem[wr_ptr_reg] <= push_data;
    end

    assign mem_req_o     = req_reg;
    assign mem_addr_o    = fetch_pc_reg;
    assign instr_valid_o = valid_reg;
    assign instr_o       = instr_reg;
    assign instr_pc_o    = instr_pc_reg;
    assign misalign_o    = misalign_reg;

`ifndef SYNTHESIS
    rvalid_has_owner: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        mem_rvalid_i |-> ((outstanding_reg != '0) || (discard_reg != '0)));
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: memory model with variable latency, expected instruction stream in a
// scoreboard queue, and a negedge monitor that checks every consumed instruction.
module tb_ifetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        misalign_o;

    ifetch_unit dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .misalign_o    (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] model_pc;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          grants = 0;
    int          pop_cnt = 0;
    int          gnt_pct = 100;
    int          ready_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          await_first = 1'b0;
    logic [31:0] first_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_val);
        vectors++;
        if (act !== req_val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req_val);
        end
        else
            $display("ok   %s: %h", name, act);
    endtask

    // One bus cycle; called just after a rising edge, returns just after the next one.
    task automatic cycle(input bit do_redir, input logic [31:0] tgt);
        bit g;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
        g = ($urandom_range(99) < gnt_pct);
        mem_gnt_i = g;
        if (mem_req_o && g) begin
            chk("gnt_addr", mem_addr_o, model_pc);
            exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            pend_q.push_back('{addr: mem_addr_o, due: cyc + $urandom_range(lat_max, lat_min)});
            model_pc = model_pc + 32'd4;
            grants++;
        end
        instr_ready_i = do_redir ? 1'b0 : ($urandom_range(99) < ready_pct);
        redirect_i    = do_redir;
        redirect_pc_i = tgt;
        if (do_redir) begin
            exp_q.delete();
            model_pc    = tgt & ~32'd3;
            first_pc    = 32'hFFFF_FFFF;
            await_first = 1'b1;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        redirect_i = 1'b0;
        if (do_redir && pend_q.size() > 0)
            chk("req_low_in_flush", {31'd0, mem_req_o}, 32'd0);
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i && instr_valid_o && instr_ready_i && !redirect_i) begin
            exp_t e;
            pop_cnt++;
            if (await_first) begin
                first_pc    = instr_pc_o;
                await_first = 1'b0;
            end
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pop: got pc %h expected no instruction", instr_pc_o);
            end else begin
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc_o, e.pc);
                chk("instr", instr_o, e.instr);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a0;
        int p0;
        rst_n_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0; instr_ready_i = 1'b0;
        model_pc = 32'h0;
        #12;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", instr_pc_o, 32'h0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

        // Backpressure: exactly DEPTH grants fill the FIFO, then requests stop.
        gnt_pct = 100; ready_pct = 0; lat_min = 1; lat_max = 1;
        repeat (12) cycle(1'b0, '0);
        chk("full_grants", grants, 32'd4);
        chk("full_req_low", {31'd0, mem_req_o}, 32'd0);
        chk("full_valid", {31'd0, instr_valid_o}, 32'd1);
        ready_pct = 100;
        repeat (10) cycle(1'b0, '0);
        chk("req_resumes", {31'd0, grants > 4}, 32'd1);

        // Streaming: one instruction per cycle.
        repeat (10) cycle(1'b0, '0);
        p0 = pop_cnt;
        repeat (20) cycle(1'b0, '0);
        chk("throughput", pop_cnt - p0, 32'd20);

        // Redirect with requests in flight, then redirect coinciding with gnt and rvalid.
        lat_min = 3; lat_max = 3;
        repeat (6) cycle(1'b0, '0);
        cycle(1'b1, 32'h100);
        repeat (14) cycle(1'b0, '0);
        chk("first_pc_redirect", first_pc, 32'h100);
        lat_min = 1; lat_max = 1;
        repeat (5) cycle(1'b0, '0);
        cycle(1'b1, 32'h240);
        repeat (10) cycle(1'b0, '0);
        chk("first_pc_redirect_gnt", first_pc, 32'h240);

        // Stalled grant keeps the request and address stable.
        gnt_pct = 0;
        repeat (4) cycle(1'b0, '0);
        a0 = mem_addr_o;
        chk("stall_req", {31'd0, mem_req_o}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0);
            chk("stall_addr", mem_addr_o, a0);
            chk("stall_req_hold", {31'd0, mem_req_o}, 32'd1);
        end

        // Asynchronous reset in the middle of a burst.
        gnt_pct = 100; lat_min = 1; lat_max = 2;
        repeat (6) cycle(1'b0, '0);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("arst_req", {31'd0, mem_req_o}, 32'd0);
        chk("arst_addr", mem_addr_o, 32'h0);
        chk("arst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("arst_instr", instr_o, 32'h0);
        chk("arst_pc", instr_pc_o, 32'h0);
        exp_q.delete(); pend_q.delete(); model_pc = 32'h0; await_first = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; instr_ready_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        repeat (10) cycle(1'b0, '0);
        chk("post_reset_stream", {31'd0, pop_cnt > p0 + 20}, 32'd1);

`ifdef FETCH_MISALIGN_CHECK_EN
        cycle(1'b1, 32'h102);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0);
            chk("misalign_set", {31'd0, misalign_o}, 32'd1);
            chk("misalign_no_req", {31'd0, mem_req_o}, 32'd0);
        end
        cycle(1'b1, 32'h200);
        repeat (10) cycle(1'b0, '0);
        chk("misalign_clear", {31'd0, misalign_o}, 32'd0);
        chk("first_pc_aligned", first_pc, 32'h200);
`else
        cycle(1'b1, 32'h102);
        repeat (10) cycle(1'b0, '0);
        chk("misalign_tied", {31'd0, misalign_o}, 32'd0);
        chk("first_pc_forced_align", first_pc, 32'h100);
`endif

        // Random traffic with occasional redirects.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            if (i % 40 == 0) begin
                gnt_pct   = $urandom_range(100, 30);
                ready_pct = $urandom_range(100, 30);
                lat_max   = $urandom_range(4, 1);
            end
            tgt = $urandom & 32'h0000_FFFC;
`ifndef FETCH_MISALIGN_CHECK_EN
            tgt = tgt | 32'($urandom_range(3));
`endif
            cycle($urandom_range(24) == 0, tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
